// File: rtl/hex_display_scanner.sv
// Eight-digit multiplexed hex display driver with halt indicator on the digit-0 decimal point.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module hex_display_scanner #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] hex_in,
  input  logic        load,
  input  logic        halt,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n
);

  localparam logic [15:0] CNT_MAX = 16'(REFRESH_DIV - 1);

  logic [31:0] disp_r;
  logic [15:0] cnt_r;
  logic [2:0]  idx_r;
  logic        halt_r;

  logic        wrap_s;
  logic [3:0]  nib_s;
  logic        blank_s;
  logic [6:0]  seg_s;

  // Active-low gfedcba font for a single hex nibble.
  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] f;
    case (v)
      4'h0:    f = 7'h40;
      4'h1:    f = 7'h79;
      4'h2:    f = 7'h24;
      4'h3:    f = 7'h30;
      4'h4:    f = 7'h19;
      4'h5:    f = 7'h12;
      4'h6:    f = 7'h02;
      4'h7:    f = 7'h78;
      4'h8:    f = 7'h00;
      4'h9:    f = 7'h10;
      4'hA:    f = 7'h08;
      4'hB:    f = 7'h03;
      4'hC:    f = 7'h46;
      4'hD:    f = 7'h21;
      4'hE:    f = 7'h06;
      4'hF:    f = 7'h0E;
      default: f = 7'h7F;
    endcase
    return f;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0] msn_s;

  // Locate the most significant nonzero nibble; an all-zero value keeps digit 0 lit.
  always_comb begin
    msn_s = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (disp_r[4*i +: 4] != 4'h0) begin
        msn_s = 3'(i);
      end else begin
        msn_s = msn_s;
      end
    end
  end
`endif

  // Prescaler wrap detect and segment pattern for the currently selected digit.
  always_comb begin
    wrap_s = (cnt_r == CNT_MAX);
    nib_s  = disp_r[{idx_r, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    blank_s = (idx_r > msn_s);
`else
    blank_s = 1'b0;
`endif
    if (blank_s) begin
      seg_s = 7'h7F;
    end else begin
      seg_s = hex_font(nib_s);
    end
  end

  // Display/halt capture, scan sequencing and registered display drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_r <= 32'h0000_0000;
      cnt_r  <= 16'd0;
      idx_r  <= 3'd0;
      halt_r <= 1'b0;
      an_n   <= 8'hFF;
      seg_n  <= 7'h7F;
      dp_n   <= 1'b1;
    end else begin
      if (load) begin
        disp_r <= hex_in;
      end
      if (halt) begin
        halt_r <= 1'b1;
      end
      if (wrap_s) begin
        cnt_r <= 16'd0;
        idx_r <= idx_r + 3'd1;
      end else begin
        cnt_r <= cnt_r + 16'd1;
      end
      an_n  <= ~(8'h01 << idx_r);
      seg_n <= seg_s;
      dp_n  <= ~((idx_r == 3'd0) & halt_r);
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench: two scanner instances (refresh divider 4 and 1) driven by shared directed stimulus.
module tb_hex_display_scanner;

  logic        clk;
  logic        rst_n;
  logic [31:0] hex_in;
  logic        load;
  logic        halt;
  logic [7:0]  an4, an1;
  logic [6:0]  seg4, seg1;
  logic        dp4, dp1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          k;
    logic [15:0] e4;
    logic [15:0] e1;
  } exp_t;

  exp_t sb[$];

  // Hand-entered active-low 0-F font (gfedcba)
  logic [6:0] font_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          edge_k;
  logic [31:0] e_disp;
  logic        e_halt;

  hex_display_scanner #(.REFRESH_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .hex_in(hex_in), .load(load), .halt(halt),
    .an_n(an4), .seg_n(seg4), .dp_n(dp4)
  );

  hex_display_scanner #(.REFRESH_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .hex_in(hex_in), .load(load), .halt(halt),
    .an_n(an1), .seg_n(seg1), .dp_n(dp1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {an_n, seg_n, dp_n} produced by edge number edge_k for divider d.
  function automatic logic [15:0] model(input int d);
    int         idx;
    int         top;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    idx = (edge_k / d) % 8;
    an = 8'hFF;
    an[idx] = 1'b0;
    seg = font_tbl[e_disp[idx*4 +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
    top = 7;
    while (top > 0 && e_disp[top*4 +: 4] == 4'h0) top--;
    if (idx > top) seg = 7'h7F;
`else
    top = 0;
`endif
    dp = !(idx == 0 && e_halt);
    return {an, seg, dp};
  endfunction

  // Called right after a falling edge: drive inputs, queue the response of the coming edge.
  task automatic step(input logic [31:0] h, input logic l, input logic hl);
    exp_t e;
    hex_in = h;
    load   = l;
    halt   = hl;
    e.k  = edge_k;
    e.e4 = model(4);
    e.e1 = model(1);
    sb.push_back(e);
    if (l) e_disp = h;
    if (hl) e_halt = 1'b1;
    edge_k++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({an4, seg4, dp4} !== {8'hFF, 7'h7F, 1'b1} || {an1, seg1, dp1} !== {8'hFF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL %s: got div4 an=%h seg=%h dp=%b div1 an=%h seg=%h dp=%b, want an=ff seg=7f dp=1",
               name, an4, seg4, dp4, an1, seg1, dp1);
    end
  endtask

  // Called right after a falling edge; ends on the falling edge at which reset is released.
  task automatic do_reset(input string name);
    hex_in = 32'h0;
    load   = 1'b0;
    halt   = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(name);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_k = 0;
    e_disp = 32'h0;
    e_halt = 1'b0;
  endtask

  // Monitor: the DUT presents a fresh output every edge; compare against the queued entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({an4, seg4, dp4} !== e.e4) begin
          errors++;
          $display("FAIL div4 edge %0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                   e.k, an4, seg4, dp4, e.e4[15:8], e.e4[7:1], e.e4[0]);
        end
        checks++;
        if ({an1, seg1, dp1} !== e.e1) begin
          errors++;
          $display("FAIL div1 edge %0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                   e.k, an1, seg1, dp1, e.e1[15:8], e.e1[7:1], e.e1[0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b1;
    hex_in = 32'h0;
    load   = 1'b0;
    halt   = 1'b0;
    edge_k = 0;
    e_disp = 32'h0;
    e_halt = 1'b0;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("power_on_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release shows digit 0 = '0'; then scan 0xAF with divider 4
    idle(2);
    step(32'h0000_00AF, 1'b1, 1'b0);
    idle(36);

    // Halt pulse: dp lit on digit 0 from then on
    step(32'h0, 1'b0, 1'b1);
    idle(36);

    // Mid-scan reset with a full value loaded
    step(32'h1234_5678, 1'b1, 1'b0);
    idle(11);
    do_reset("midscan_reset");
    idle(3);

    // Load and halt on the same edge
    step(32'hFFFF_FFFF, 1'b1, 1'b1);
    idle(35);

    // Leading-zero case
    do_reset("reset_before_blank");
    step(32'h0000_0010, 1'b1, 1'b0);
    idle(35);

    // Load coincident with a digit advance of the divider-4 instance
    while ((edge_k % 4) != 3) step(32'h0, 1'b0, 1'b0);
    step(32'h8765_4321, 1'b1, 1'b0);
    idle(34);

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, meaning clock cycles each digit stays selected (legal range 1..65535).
REQ-002 The block SHALL have port clk  input  1  system clock, all state on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port hex_in  input  32  value to display, sourced from the syscall decoder hex output.
REQ-005 The block SHALL have port load  input  1  capture strobe for hex_in, tied to the syscall enable.
REQ-006 The block SHALL have port halt  input  1  CPU halt indication from the syscall decoder.
REQ-007 The block SHALL have port an_n  output  8  digit anodes, active-low, an_n[i] selects digit i.
REQ-008 The block SHALL have port seg_n  output  7  segments, active-low, seg_n[0]=a ... seg_n[6]=g.
REQ-009 The block SHALL have port dp_n  output  1  decimal point, active-low.

Function
REQ-010 Display register disp_q SHALL load hex_in on any rising edge with load=1 and hold otherwise.
REQ-011 Prescaler cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; on the wrap cycle digit index idx SHALL advance by 1, wrapping 7->0.
REQ-012 With REFRESH_DIV=1, idx SHALL advance on every clock.
REQ-013 Digit idx SHALL show nibble disp_q[4*idx+3 : 4*idx]; digit 0 is the least significant nibble.
REQ-014 Segment encoding SHALL be the standard 0-F hex font, e.g. 0->7'h40, 1->7'h79, 8->7'h00, A->7'h08, F->7'h0E (seg_n[6:0]).
REQ-015 an_n, seg_n and dp_n SHALL be registered and reflect idx/disp_q/halt_q from the previous cycle (1-cycle latency).
REQ-016 Exactly one an_n bit SHALL be low in every cycle after the first post-reset clock.
REQ-017 Halt flag halt_q SHALL be set on any rising edge with halt=1 and SHALL be cleared only by reset.
REQ-018 dp_n SHALL be low only when the selected digit is 0 and halt_q=1; high otherwise.
REQ-019 load and halt asserted in the same cycle SHALL both take effect on that edge.
REQ-020 load asserted on the same edge as an idx advance SHALL have the new value visible on the newly selected digit one cycle later.

Reset
REQ-021 rst_n low SHALL immediately force disp_q=0, cnt=0, idx=0, halt_q=0, an_n=8'hFF, seg_n=7'h7F, dp_n=1, regardless of clk, including mid-scan.
REQ-022 The first rising edge after rst_n deasserts SHALL produce an_n=8'hFE, seg_n=7'h40, dp_n=1.

Configuration
REQ-023 Macro LEADING_ZERO_BLANK_EN, when defined, SHALL blank (seg_n=7'h7F, dp_n unaffected) every digit above the most significant nonzero nibble of disp_q; digit 0 SHALL never be blanked; an_n scanning SHALL be unchanged.
REQ-024 Without LEADING_ZERO_BLANK_EN, all eight digits SHALL always show their nibble, including leading zeros.

Verification
REQ-025 Reset: rst_n low mid-scan with disp_q=32'h12345678 -> an_n=8'hFF, seg_n=7'h7F, dp_n=1 asynchronously; first edge after release -> an_n=8'hFE, seg_n=7'h40.
REQ-026 Scan: REFRESH_DIV=4, load hex_in=32'h0000_00AF -> each an_n value held 4 cycles, sequence FE,FD,FB,...,7F,FE; digit 0 seg_n=7'h0E, digit 1 seg_n=7'h08.
REQ-027 Halt: pulse halt=1 for one cycle -> dp_n low whenever an_n=8'hFE, high on other digits, persists until rst_n.
REQ-028 Simultaneous: load=1 with hex_in=32'hFFFF_FFFF and halt=1 on the same edge -> all digits seg_n=7'h0E, dp_n low on digit 0.
REQ-029 Config: hex_in=32'h0000_0010 loaded -> with LEADING_ZERO_BLANK_EN digits 2..7 seg_n=7'h7F, digit 1 7'h79, digit 0 7'h40; without it digits 2..7 seg_n=7'h40.
REQ-030 Edge: REFRESH_DIV=1 -> an_n changes every cycle, full 8-digit cycle in 8 clocks.
